// File: rtl/rv32_mod_ifetch_align.sv
// Instruction fetch and RVC realigner: two-word buffer in front of a single-outstanding word bus.
// Define RV32_COMPRESSED_EN for 16-bit and word-straddling instructions; otherwise 32-bit aligned only.
module rv32_mod_ifetch_align #(
  parameter logic [31:0] FAULT_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        decode_ready,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        is_compressed,
  output logic        instr_fault,
  output logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [29:0] req_addr_q, req_addr_d;
  logic        pending_err_q, pending_err_d;
  logic        drop_q, drop_d;
  logic [1:0]  ent_valid_q, ent_valid_d;
  logic [29:0] ent_addr_q [2];
  logic [31:0] ent_data_q [2];

  logic [29:0] lo_addr;
  logic [1:0]  lo_hold;
  logic        lo_hit;
  logic [31:0] lo_data;
  logic        fetch_req;
  logic [29:0] fetch_addr;
  logic        fill_sel;
  logic        wr_en;
  logic        unused_pc0;

  assign lo_addr    = pc[31:2];
  assign unused_pc0 = pc[0];

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    lo_hold = '0;
    for (int i = 0; i < 2; i++) begin
      lo_hold[i] = ent_valid_q[i] && (ent_addr_q[i] == lo_addr);
    end
    lo_data = lo_hold[1] ? ent_data_q[1] : ent_data_q[0];
  end

  assign lo_hit = |lo_hold;

`ifdef RV32_COMPRESSED_EN
  logic [29:0] hi_addr;
  logic        hi_hit;
  logic [15:0] hi_half;
  logic [15:0] half;
  logic        half_comp;
  logic        need_hi;

  // 30-bit word index wraps naturally, so HI of the last word is word 0.
  assign hi_addr = lo_addr + 30'd1;

  always_comb begin
    hi_hit  = 1'b0;
    hi_half = '0;
    for (int i = 0; i < 2; i++) begin
      if (ent_valid_q[i] && (ent_addr_q[i] == hi_addr)) begin
        hi_hit  = 1'b1;
        hi_half = ent_data_q[i][15:0];
      end
    end
  end

  assign half      = pc[1] ? lo_data[31:16] : lo_data[15:0];
  assign half_comp = (half[1:0] != 2'b11);
  assign need_hi   = pc[1] && !half_comp;

  always_comb begin
    instr         = '0;
    instr_valid   = 1'b0;
    is_compressed = 1'b0;
    instr_fault   = 1'b0;
    fetch_req     = 1'b0;
    fetch_addr    = lo_addr;
    if (pending_err_q) begin
      instr_valid = 1'b1;
      instr_fault = 1'b1;
      instr       = FAULT_INSTR;
    end else if (!lo_hit) begin
      fetch_req = 1'b1;
    end else if (need_hi && !hi_hit) begin
      fetch_req  = 1'b1;
      fetch_addr = hi_addr;
    end else begin
      instr_valid   = 1'b1;
      is_compressed = half_comp;
      if (half_comp) instr = {16'h0000, half};
      else if (need_hi) instr = {hi_half, lo_data[31:16]};
      else instr = lo_data;
    end
  end
`else
  always_comb begin
    instr         = '0;
    instr_valid   = 1'b0;
    is_compressed = 1'b0;
    instr_fault   = 1'b0;
    fetch_req     = 1'b0;
    fetch_addr    = lo_addr;
    // A halfword-aligned pc cannot hold a 32-bit instruction here; fault without fetching.
    if (pending_err_q || pc[1]) begin
      instr_valid = 1'b1;
      instr_fault = 1'b1;
      instr       = FAULT_INSTR;
    end else if (!lo_hit) begin
      fetch_req = 1'b1;
    end else begin
      instr_valid = 1'b1;
      instr       = lo_data;
    end
  end
`endif

  // Refill the entry that does not hold LO so a straddling pair stays resident.
  assign fill_sel = lo_hold[0] && !lo_hold[1];

  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    pending_err_d = pending_err_q;
    drop_d        = drop_q;
    ent_valid_d   = ent_valid_q;
    wr_en         = 1'b0;

    if (pending_err_q && decode_ready) pending_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fetch_req && !flush) begin
          state_d    = ST_REQ;
          req_addr_d = fetch_addr;
        end
      end
      ST_REQ: begin
        if (imem_ack) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
          if (!drop_q && !flush) begin
            wr_en                 = 1'b1;
            ent_valid_d[fill_sel] = !imem_err;
            if (imem_err) pending_err_d = 1'b1;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      ent_valid_d   = '0;
      pending_err_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      req_addr_q    <= '0;
      pending_err_q <= 1'b0;
      drop_q        <= 1'b0;
      ent_valid_q   <= '0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      pending_err_q <= pending_err_d;
      drop_q        <= drop_d;
      ent_valid_q   <= ent_valid_d;
    end
  end

  // NOTE: buffer payload is not reset; the reset valid bits make its contents irrelevant.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ent_addr_q[fill_sel] <= req_addr_q;
      ent_data_q[fill_sel] <= imem_rdata;
    end
  end

  assign imem_req  = (state_q == ST_REQ);
  assign imem_addr = {req_addr_q, 2'b00};
  assign stall     = !(instr_valid && decode_ready);

endmodule

// File: tb/tb_rv32_mod_ifetch_align.sv
// Bench for rv32_mod_ifetch_align: directed scenarios plus a randomized run against a
// word-level memory model that derives each expected instruction from pc and memory contents.
module tb_rv32_mod_ifetch_align;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc;
  logic        flush;
  logic        decode_ready;
  logic [31:0] instr;
  logic        instr_valid;
  logic        is_compressed;
  logic        instr_fault;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;

  logic        r_ack = 1'b0, man_ack = 1'b0;
  logic [31:0] r_rdata = '0, man_rdata = '0;
  logic        r_err = 1'b0, man_err = 1'b0;
  bit          resp_en = 1'b0;
  bit          rand_err_en = 1'b0;
  int          dmin = 0, dmax = 0;
  int          cyc = 0;
  int          ack_cyc = 0;
  logic [31:0] req_log [$];
  logic [31:0] mem_ovr [logic [31:0]];
  bit          err_ovr [logic [31:0]];

  int total = 0;
  int bad   = 0;

  assign imem_ack   = resp_en ? r_ack   : man_ack;
  assign imem_rdata = resp_en ? r_rdata : man_rdata;
  assign imem_err   = resp_en ? r_err   : man_err;

  rv32_mod_ifetch_align dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pc           (pc),
    .flush        (flush),
    .decode_ready (decode_ready),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .is_compressed(is_compressed),
    .instr_fault  (instr_fault),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .imem_err     (imem_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] x;
    if (mem_ovr.exists(a)) return mem_ovr[a];
    x = (a ^ 32'h5bd1_e995) * 32'h9e37_79b1;
    x = x ^ (x >> 15);
    return x;
  endfunction

  function automatic bit mem_err(input logic [31:0] a);
    logic [31:0] x;
    if (err_ovr.exists(a)) return err_ovr[a];
    x = a * 32'h85eb_ca6b;
    return rand_err_en && (x[31:27] == 5'd0);
  endfunction

  // Reference: what the instruction at p is, given memory contents and bus errors.
  task automatic ref_fetch(input logic [31:0] p, output logic [31:0] ins,
                           output logic cmp, output logic flt);
    logic [31:0] lo_a, hi_a, w_lo, w_hi;
    logic [15:0] half;
    lo_a = {p[31:2], 2'b00};
    hi_a = lo_a + 32'd4;
    w_lo = mem_word(lo_a);
    w_hi = mem_word(hi_a);
    ins  = 32'h0000_0013;
    cmp  = 1'b0;
    flt  = 1'b1;
`ifdef RV32_COMPRESSED_EN
    half = p[1] ? w_lo[31:16] : w_lo[15:0];
    if (mem_err(lo_a)) begin
      flt = 1'b1;
    end else if (half[1:0] != 2'b11) begin
      ins = {16'h0000, half}; cmp = 1'b1; flt = 1'b0;
    end else if (!p[1]) begin
      ins = w_lo; flt = 1'b0;
    end else if (!mem_err(hi_a)) begin
      ins = {w_hi[15:0], half}; flt = 1'b0;
    end
`else
    half = w_hi[15:0];
    if (!p[1] && !mem_err(lo_a)) begin
      ins = w_lo; flt = 1'b0;
    end
`endif
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    if ($urandom_range(0, 3) == 0) p = 32'hFFFF_FFF0 + 32'($urandom_range(0, 7) * 2);
    else p = 32'h0000_1000 + 32'($urandom_range(0, 255) * 2);
`ifndef RV32_COMPRESSED_EN
    if ($urandom_range(0, 7) != 0) p[1] = 1'b0;
`endif
    return p;
  endfunction

  // Memory responder: random latency, one request at a time, logs each acknowledged address.
  always begin : responder
    bit          pend;
    int          cnt, target;
    logic [31:0] hold_addr;
    @(posedge clk);
    #1;
    r_ack = 1'b0;
    if (!reset_n || !resp_en || !imem_req) begin
      pend = 1'b0;
    end else begin
      if (!pend) begin
        pend = 1'b1; cnt = 0; target = int'($urandom_range(dmin, dmax));
        hold_addr = imem_addr;
        check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
      end else begin
        check("addr_stable", imem_addr, hold_addr);
      end
      if (cnt >= target) begin
        r_ack   = 1'b1;
        r_rdata = mem_word(imem_addr);
        r_err   = mem_err(imem_addr);
        req_log.push_back(imem_addr);
        ack_cyc = cyc;
        pend    = 1'b0;
      end else begin
        cnt++;
      end
    end
  end

  task automatic step(input logic [31:0] p, input logic f, input logic r);
    @(posedge clk);
    #1;
    pc = p; flush = f; decode_ready = r;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    bit got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (instr_valid === 1'b1) begin got = 1'b1; break; end
      step(pc, 1'b0, decode_ready);
    end
    check({tag, "_timeout"}, {31'd0, got}, 32'd1);
  endtask

  initial begin
    int          log_n, vcyc, waitc;
    logic [31:0] cur_pc, e_ins;
    logic        e_cmp, e_flt, do_flush;

    mem_ovr[32'h0000_0000] = 32'h0050_0093;
    mem_ovr[32'h0000_0100] = 32'h0050_0093;
    mem_ovr[32'h0000_0180] = 32'h4505_0001;
    mem_ovr[32'h0000_0104] = 32'h0093_abcd;
    mem_ovr[32'h0000_0108] = 32'h1234_0050;
    mem_ovr[32'h0000_0200] = 32'h0010_0113;
    mem_ovr[32'h0000_0400] = 32'h0020_0193;
    mem_ovr[32'h0000_0304] = 32'h0050_0093;
    err_ovr[32'h0000_0300] = 1'b1;

    reset_n = 1'b0; pc = '0; flush = 1'b0; decode_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_comp", {31'd0, is_compressed}, 32'd0);
    check("rst_fault", {31'd0, instr_fault}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd1);

    // Reset in the middle of a request, then a stray ack that must be ignored.
    reset_n = 1'b1;
    step(32'h0, 1'b0, 1'b0);
    check("t1_req", {31'd0, imem_req}, 32'd1);
    check("t1_addr", imem_addr, 32'h0);
    #1 reset_n = 1'b0;
    #1;
    check("t1_rst_req", {31'd0, imem_req}, 32'd0);
    check("t1_rst_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    man_ack = 1'b1; man_rdata = 32'hdead_beef; man_err = 1'b0;
    @(posedge clk);
    #1 man_ack = 1'b0;
    @(negedge clk);
    check("t1_late_valid", {31'd0, instr_valid}, 32'd0);
    check("t1_rereq", {31'd0, imem_req}, 32'd1);
    resp_en = 1'b1;
    wait_valid("t1", 20);
    check("t1_instr", instr, 32'h0050_0093);

    // Aligned miss with a two-cycle bus latency.
    dmin = 2; dmax = 2;
    step(32'h100, 1'b1, 1'b0);
    wait_valid("t2", 20);
    vcyc = cyc;
    check("t2_latency", vcyc - ack_cyc, 32'd1);
    check("t2_instr", instr, 32'h0050_0093);
    check("t2_comp", {31'd0, is_compressed}, 32'd0);
    check("t2_fault", {31'd0, instr_fault}, 32'd0);

    // Two halves of one buffered word.
    dmin = 0; dmax = 1;
    step(32'h180, 1'b1, 1'b0);
    wait_valid("t3a", 20);
`ifdef RV32_COMPRESSED_EN
    check("t3a_instr", instr, 32'h0000_0001);
    check("t3a_comp", {31'd0, is_compressed}, 32'd1);
`else
    check("t3a_instr", instr, 32'h4505_0001);
    check("t3a_comp", {31'd0, is_compressed}, 32'd0);
`endif
    step(32'h180, 1'b0, 1'b1);
    log_n = req_log.size();
    step(32'h182, 1'b0, 1'b0);
    check("t3b_valid", {31'd0, instr_valid}, 32'd1);
    check("t3b_req", {31'd0, imem_req}, 32'd0);
`ifdef RV32_COMPRESSED_EN
    check("t3b_instr", instr, 32'h0000_4505);
    check("t3b_comp", {31'd0, is_compressed}, 32'd1);
`else
    check("t3b_instr", instr, 32'h0000_0013);
    check("t3b_fault", {31'd0, instr_fault}, 32'd1);
`endif
    step(32'h182, 1'b0, 1'b1);
    check("t3b_no_fetch", req_log.size() - log_n, 32'd0);

    // Instruction straddling two words.
    log_n = req_log.size();
    step(32'h106, 1'b1, 1'b0);
`ifdef RV32_COMPRESSED_EN
    wait_valid("t4", 30);
    check("t4_instr", instr, 32'h0050_0093);
    check("t4_comp", {31'd0, is_compressed}, 32'd0);
    check("t4_nreq", req_log.size() - log_n, 32'd2);
    if (req_log.size() >= log_n + 2) begin
      check("t4_req0", req_log[log_n], 32'h104);
      check("t4_req1", req_log[log_n + 1], 32'h108);
    end
`else
    step(32'h106, 1'b0, 1'b0);
    check("t4_fault", {31'd0, instr_fault}, 32'd1);
    check("t4_valid", {31'd0, instr_valid}, 32'd1);
    step(32'h106, 1'b0, 1'b0);
    check("t4_nreq", req_log.size() - log_n, 32'd0);
`endif

    // Flush while a request is outstanding.
    resp_en = 1'b0;
    dmin = 1; dmax = 1;
    step(32'h200, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (imem_req) break;
      step(32'h200, 1'b0, 1'b0);
    end
    check("t5_req_seen", {31'd0, imem_req}, 32'd1);
    check("t5_req_addr", imem_addr, 32'h200);
    step(32'h400, 1'b1, 1'b0);
    step(32'h400, 1'b0, 1'b0);
    check("t5_hold_req", {31'd0, imem_req}, 32'd1);
    check("t5_hold_addr", imem_addr, 32'h200);
    log_n = req_log.size();
    resp_en = 1'b1;
    wait_valid("t5", 30);
    check("t5_instr", instr, 32'h0020_0193);
    check("t5_nreq", req_log.size() - log_n, 32'd2);
    if (req_log.size() >= log_n + 2) begin
      check("t5_req0", req_log[log_n], 32'h200);
      check("t5_req1", req_log[log_n + 1], 32'h400);
    end

    // Bus error reported as a fault until consumed.
    step(32'h300, 1'b1, 1'b0);
    wait_valid("t6", 20);
    check("t6_fault", {31'd0, instr_fault}, 32'd1);
    check("t6_instr", instr, 32'h0000_0013);
    check("t6_comp", {31'd0, is_compressed}, 32'd0);
    check("t6_stall", {31'd0, stall}, 32'd1);
    step(32'h300, 1'b0, 1'b1);
    check("t6_hold_fault", {31'd0, instr_fault}, 32'd1);
    check("t6_nostall", {31'd0, stall}, 32'd0);
    step(32'h304, 1'b0, 1'b0);
    check("t6_clear_fault", {31'd0, instr_fault}, 32'd0);
    check("t6_clear_valid", {31'd0, instr_valid}, 32'd0);
    wait_valid("t6b", 20);
    check("t6b_instr", instr, 32'h0050_0093);

    // Randomized run: sequential flow, jumps via flush, wrap at the top of memory, bus errors.
    dmin = 0; dmax = 3; rand_err_en = 1'b1;
    cur_pc = rand_pc();
    waitc = 0;
    for (int i = 0; i < 4000; i++) begin
      do_flush = (i == 0) || ($urandom_range(0, 99) < 6);
      if (do_flush) cur_pc = rand_pc();
      step(cur_pc, do_flush, do_flush ? 1'b0 : ($urandom_range(0, 3) != 0));
      if (do_flush) begin
        waitc = 0;
        continue;
      end
      if (instr_valid) begin
        ref_fetch(cur_pc, e_ins, e_cmp, e_flt);
        check("rnd_instr", instr, e_ins);
        check("rnd_comp", {31'd0, is_compressed}, {31'd0, e_cmp});
        check("rnd_fault", {31'd0, instr_fault}, {31'd0, e_flt});
        check("rnd_stall", {31'd0, stall}, {31'd0, !decode_ready});
        if (decode_ready) cur_pc = cur_pc + (e_cmp ? 32'd2 : 32'd4);
        waitc = 0;
      end else begin
        check("rnd_stall_idle", {31'd0, stall}, 32'd1);
        waitc++;
        if (waitc > 60) begin
          check("rnd_timeout", waitc, 32'd0);
          waitc = 0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
